// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Purpose  : Sequential instruction prefetcher with credit-limited in-flight
//            requests, PC-tagged FIFO and flush redirect with stale-drop count.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];

    logic [SUM_W-1:0] credit_used;
    logic             grant;
    logic             push;
    logic             pop;
    logic             drop_hit;
    logic [CNT_W-1:0] drop_sum;
    logic [31:0]      flush_pc_aligned;

    // Occupancy plus everything still owed by memory bounds new requests,
    // so a returning response always has a free FIFO slot.
    assign credit_used = SUM_W'(count) + SUM_W'(outstanding) + SUM_W'(drop);
    assign mem_req     = !rst && !flush && (credit_used < SUM_W'(DEPTH));
    assign mem_addr    = rst ? RESET_PC : fetch_pc;
    assign grant       = mem_req && mem_gnt;

    assign drop_hit = mem_rvalid && (drop != '0);
    assign push     = mem_rvalid && (drop == '0) && (outstanding != '0);

    assign inst_valid = !rst && (count != '0);
    assign inst       = inst_valid ? fifo_data[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign pop        = inst_valid && inst_ready;

    assign flush_pc_aligned = {flush_pc[31:2], 2'b00};
    assign drop_sum         = drop + outstanding;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (flush) begin
            // Everything in flight becomes stale; a response landing this
            // cycle retires one of those stale requests immediately.
            fetch_pc    <= flush_pc_aligned;
            resp_pc     <= flush_pc_aligned;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            drop        <= drop_sum - CNT_W'((mem_rvalid && (drop_sum != '0)) ? 1 : 0);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (drop_hit) begin
                drop <= drop - CNT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({grant, push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_data[wr_ptr] <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_queue
// Purpose  : Directed self-checking bench for inst_prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_queue;

    localparam logic [31:0] XOR_PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_req2;
    logic [31:0] mem_addr, mem_addr2;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid, mem_rvalid2;
    logic [31:0] mem_rdata, mem_rdata2;
    logic        inst_valid, inst_valid2;
    logic [31:0] inst, inst2, inst_pc, inst_pc2;
    logic        inst_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;

    logic        auto_resp = 1'b0;
    logic        resp_valid = 1'b0, resp_valid2 = 1'b0;
    logic [31:0] resp_data = 32'h0, resp_data2 = 32'h0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .flush(flush), .flush_pc(flush_pc)
    );

    // Second instance exercises address wrap; always granted and drained.
    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_gnt(1'b1),
        .mem_rvalid(mem_rvalid2), .mem_rdata(mem_rdata2), .inst_valid(inst_valid2), .inst(inst2),
        .inst_pc(inst_pc2), .inst_ready(1'b1), .flush(1'b0), .flush_pc(32'h0)
    );

    // Memory models: answer one cycle after grant with addr ^ XOR_PAT.
    always @(posedge clk) begin
        resp_valid  <= auto_resp && mem_req && mem_gnt;
        resp_data   <= mem_addr ^ XOR_PAT;
        resp_valid2 <= mem_req2;
        resp_data2  <= mem_addr2 ^ XOR_PAT;
    end

    assign mem_rvalid  = auto_resp ? resp_valid : man_rvalid;
    assign mem_rdata   = auto_resp ? resp_data  : man_rdata;
    assign mem_rvalid2 = resp_valid2;
    assign mem_rdata2  = resp_data2;

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after reset.
    task automatic do_reset;
        next_cyc();
        rst = 1'b1; flush = 1'b0; mem_gnt = 1'b0; inst_ready = 1'b0;
        man_rvalid = 1'b0; auto_resp = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        next_cyc();
        rst = 1'b1; flush = 1'b0; mem_gnt = 1'b1; inst_ready = 1'b1;
        man_rvalid = 1'b0; auto_resp = 1'b0;
        next_cyc();
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00000000", mem_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h/%h exp=0/0", inst, inst_pc); end
        checks++; if (mem_addr2 !== 32'hFFFF_FFF8 || mem_req2 !== 1'b0) begin failures++; $display("FAIL reset_wrap_addr got=%h req=%b exp=fffffff8 req=0", mem_addr2, mem_req2); end
    endtask

    task automatic test_stream;
        logic [31:0] pc;
        do_reset();
        mem_gnt = 1'b1; inst_ready = 1'b1; auto_resp = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) next_cyc();
            #1;
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * (c - 1))) begin failures++; $display("FAIL stream_addr c=%0d got=%b/%h exp=1/%h", c, mem_req, mem_addr, 32'(4 * (c - 1))); end
            if (c < 3) begin
                checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, inst_valid); end
            end else begin
                pc = 32'(4 * (c - 3));
                checks++; if (inst_valid !== 1'b1 || inst_pc !== pc || inst !== (pc ^ XOR_PAT)) begin
                    failures++; $display("FAIL stream_inst c=%0d got=%b pc=%h inst=%h exp=1 pc=%h inst=%h", c, inst_valid, inst_pc, inst, pc, pc ^ XOR_PAT);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int grants;
        grants = 0;
        do_reset();
        mem_gnt = 1'b1; inst_ready = 1'b0; auto_resp = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) next_cyc();
            #1;
            if (mem_req && mem_gnt) grants++;
        end
        checks++; if (grants != 4) begin failures++; $display("FAIL bp_grants got=%0d exp=4", grants); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got=%b exp=0", mem_req); end
        next_cyc(); inst_ready = 1'b1; #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || mem_req !== 1'b0) begin failures++; $display("FAIL bp_pop got=%b pc=%h req=%b exp=1 pc=0 req=0", inst_valid, inst_pc, mem_req); end
        next_cyc(); inst_ready = 1'b0; #1;
        checks++; if (inst_pc !== 32'h4 || inst !== (32'h4 ^ XOR_PAT)) begin failures++; $display("FAIL bp_next_head got=%h/%h exp=00000004/%h", inst_pc, inst, 32'h4 ^ XOR_PAT); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin failures++; $display("FAIL bp_refill got=%b/%h exp=1/00000010", mem_req, mem_addr); end
        next_cyc(); #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_refull got=%b exp=0", mem_req); end
    endtask

    task automatic test_flush_inflight;
        do_reset();
        mem_gnt = 1'b1; inst_ready = 1'b0;
        #1;                                                   // c1: grant 0x0
        next_cyc(); man_rvalid = 1'b1; man_rdata = 32'h1111_0000; #1; // c2: resp 0x0, grant 0x4
        next_cyc(); man_rvalid = 1'b0; #1;                    // c3: grant 0x8
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h1111_0000) begin failures++; $display("FAIL fl_buffered got=%b pc=%h inst=%h exp=1 pc=0 inst=11110000", inst_valid, inst_pc, inst); end
        next_cyc(); flush = 1'b1; flush_pc = 32'h0000_1003; #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fl_req_in_flush got=%b exp=0", mem_req); end
        next_cyc(); flush = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_0004; #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fl_valid_after got=%b exp=0", inst_valid); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin failures++; $display("FAIL fl_redirect got=%b/%h exp=1/00001000", mem_req, mem_addr); end
        next_cyc(); man_rdata = 32'hBAD0_0008; #1;
        checks++; if (inst_valid !== 1'b0 || mem_addr !== 32'h1004) begin failures++; $display("FAIL fl_stale1 got=%b/%h exp=0/00001004", inst_valid, mem_addr); end
        next_cyc(); mem_gnt = 1'b0; man_rdata = 32'hCAFE_1000; #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fl_stale2 got=%b exp=0", inst_valid); end
        next_cyc(); man_rvalid = 1'b0; #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1000 || inst !== 32'hCAFE_1000) begin failures++; $display("FAIL fl_first_new got=%b pc=%h inst=%h exp=1 pc=00001000 inst=cafe1000", inst_valid, inst_pc, inst); end
    endtask

    task automatic test_gnt_stall;
        do_reset();
        mem_gnt = 1'b1; inst_ready = 1'b1; auto_resp = 1'b1;
        #1;
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL stall_c1 got=%h exp=00000000", mem_addr); end
        next_cyc(); #1;
        checks++; if (mem_addr !== 32'h4) begin failures++; $display("FAIL stall_c2 got=%h exp=00000004", mem_addr); end
        for (int c = 3; c <= 5; c++) begin
            next_cyc(); mem_gnt = 1'b0; #1;
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/00000008", c, mem_req, mem_addr); end
        end
        next_cyc(); mem_gnt = 1'b1; #1;
        checks++; if (mem_addr !== 32'h8) begin failures++; $display("FAIL stall_grant got=%h exp=00000008", mem_addr); end
        next_cyc(); #1;
        checks++; if (mem_addr !== 32'hC) begin failures++; $display("FAIL stall_advance got=%h exp=0000000c", mem_addr); end
    endtask

    task automatic test_flush_with_resp;
        do_reset();
        mem_gnt = 1'b1; inst_ready = 1'b1;
        #1;                                                   // c1: grant 0x0
        next_cyc(); man_rvalid = 1'b1; man_rdata = 32'h0000_1234; #1; // c2: resp, grant 0x4
        next_cyc(); mem_gnt = 1'b0; flush = 1'b1; flush_pc = 32'h0000_2002; man_rdata = 32'hDEAD_0004; #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || mem_req !== 1'b0) begin failures++; $display("FAIL fr_flush_cycle got=%b pc=%h req=%b exp=1 pc=0 req=0", inst_valid, inst_pc, mem_req); end
        next_cyc(); flush = 1'b0; man_rvalid = 1'b0; mem_gnt = 1'b1; #1;
        checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h2000) begin failures++; $display("FAIL fr_restart got=%b req=%b addr=%h exp=0 req=1 addr=00002000", inst_valid, mem_req, mem_addr); end
        next_cyc(); mem_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h2000_BEEF; #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fr_empty got=%b exp=0", inst_valid); end
        next_cyc(); man_rvalid = 1'b0; #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h2000 || inst !== 32'h2000_BEEF) begin failures++; $display("FAIL fr_no_drop got=%b pc=%h inst=%h exp=1 pc=00002000 inst=2000beef", inst_valid, inst_pc, inst); end
        next_cyc(); #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL fr_drained got=%b exp=0", inst_valid); end
    endtask

    task automatic test_addr_wrap;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) next_cyc();
            #1;
            exp_addr = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
            checks++; if (mem_req2 !== 1'b1 || mem_addr2 !== exp_addr) begin failures++; $display("FAIL wrap_addr c=%0d got=%b/%h exp=1/%h", c, mem_req2, mem_addr2, exp_addr); end
            if (c >= 3) begin
                exp_pc = 32'hFFFF_FFF8 + 32'(4 * (c - 3));
                checks++; if (inst_valid2 !== 1'b1 || inst_pc2 !== exp_pc || inst2 !== (exp_pc ^ XOR_PAT)) begin
                    failures++; $display("FAIL wrap_pc c=%0d got=%b pc=%h inst=%h exp=1 pc=%h inst=%h", c, inst_valid2, inst_pc2, inst2, exp_pc, exp_pc ^ XOR_PAT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_reset();
        test_backpressure();
        test_flush_inflight();
        test_gnt_stall();
        test_flush_with_resp();
        test_addr_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
